// File: rtl/puf_resp_reader.sv
// rtl/puf_resp_reader.sv - butterfly PUF read controller with majority voting
module puf_resp_reader #(
  parameter int RESP_WIDTH = 8,
  parameter int VOTES      = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic [((RESP_WIDTH > 1) ? $clog2(RESP_WIDTH) : 1)-1:0] puf_sel,
  output logic                                                   puf_en,
  output logic                                                   puf_excite,
  output logic                                                   puf_clr,
  output logic                                                   puf_pre,
  input  logic                                                   puf_q,
  output logic [RESP_WIDTH-1:0]                                  resp,
  output logic                                                   resp_valid,
  input  logic                                                   resp_ready,
  output logic [$clog2(RESP_WIDTH+1)-1:0]                        unstable_cnt
);

  localparam int SEL_W  = (RESP_WIDTH > 1) ? $clog2(RESP_WIDTH) : 1;
  localparam int CNT_W  = $clog2(RESP_WIDTH + 1);
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int PH_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(SETTLE_CYC - 1);
  localparam logic [VOTE_W-1:0] VOTES_L  = VOTE_W'(VOTES);
  localparam logic [VOTE_W-1:0] HALF     = VOTE_W'(VOTES / 2);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(RESP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXCITE  = 3'd1,
    RELEASE = 3'd2,
    SAMPLE  = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [VOTE_W-1:0]   votes;
  logic [VOTE_W-1:0]   ones;
  logic [VOTE_W-1:0]   votes_inc;

  // The cell is always kept preset and never cleared by this reader.
  assign puf_clr = 1'b0;
  assign puf_pre = 1'b1;

  assign votes_inc = votes + VOTE_W'(1);

  // Sequencer: every output is a register updated on the transition into the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      puf_en       <= 1'b0;
      puf_excite   <= 1'b0;
      resp_valid   <= 1'b0;
      puf_sel      <= '0;
      resp         <= '0;
      unstable_cnt <= '0;
      votes        <= '0;
      ones         <= '0;
      phase        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            resp         <= '0;
            unstable_cnt <= '0;
            puf_sel      <= '0;
            votes        <= '0;
            ones         <= '0;
            phase        <= '0;
            busy         <= 1'b1;
            puf_en       <= 1'b1;
            puf_excite   <= 1'b1;
            state        <= EXCITE;
          end
        end

        EXCITE: begin
          if (phase == PH_LAST) begin
            phase      <= '0;
            puf_en     <= 1'b0;
            puf_excite <= 1'b0;
            state      <= RELEASE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end

        RELEASE: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            state <= SAMPLE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end

        SAMPLE: begin
          // The cell has settled after release; one evaluation is counted here.
          ones  <= ones + VOTE_W'(puf_q);
          votes <= votes_inc;
          if (votes_inc < VOTES_L) begin
            puf_en     <= 1'b1;
            puf_excite <= 1'b1;
            state      <= EXCITE;
          end else begin
            state <= NEXT;
          end
        end

        NEXT: begin
          resp[puf_sel] <= (ones > HALF);
          if ((ones != '0) && (ones != VOTES_L)) begin
            unstable_cnt <= unstable_cnt + CNT_W'(1);
          end
          votes <= '0;
          ones  <= '0;
          if (puf_sel == SEL_LAST) begin
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            puf_sel    <= puf_sel + SEL_W'(1);
            puf_en     <= 1'b1;
            puf_excite <= 1'b1;
            state      <= EXCITE;
          end
        end

        DONE: begin
          // Response and count are held until the consumer takes them; start is not looked at here.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_reader.sv
// tb/tb_puf_resp_reader.sv - scoreboard bench for puf_resp_reader
module tb_puf_resp_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_ready;
  logic       busy;
  logic [2:0] puf_sel;
  logic       puf_en;
  logic       puf_excite;
  logic       puf_clr;
  logic       puf_pre;
  logic       puf_q;
  logic [7:0] resp;
  logic       resp_valid;
  logic [3:0] unstable_cnt;

  logic       s_start;
  logic       s_ready;
  logic       s_busy;
  logic [1:0] s_sel;
  logic       s_en;
  logic       s_exc;
  logic       s_clr;
  logic       s_pre;
  logic       s_q;
  logic [3:0] s_resp;
  logic       s_valid;
  logic [2:0] s_unst;
  logic [3:0] s_pat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] resp;
    logic [3:0] unst;
    int         lat;
  } exp_t;
  exp_t sb[$];

  // seq[c][k] is the q value cell c returns on its k-th evaluation
  logic [4:0] seq [8];
  int         ev  [8];
  logic       en_prev;
  logic       model_clr;

  logic       mon_clr;
  int         n_exc, n_exc_bad, n_low, n_low_bad, n_sel_bad, hi_run, lo_run, sel_max;
  logic [2:0] last_sel;
  bit         seen;

  always #5 clk = ~clk;

  puf_resp_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .puf_sel(puf_sel),
    .puf_en(puf_en), .puf_excite(puf_excite), .puf_clr(puf_clr), .puf_pre(puf_pre),
    .puf_q(puf_q), .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .unstable_cnt(unstable_cnt)
  );

  puf_resp_reader #(.RESP_WIDTH(4), .VOTES(1), .SETTLE_CYC(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .puf_sel(s_sel),
    .puf_en(s_en), .puf_excite(s_exc), .puf_clr(s_clr), .puf_pre(s_pre),
    .puf_q(s_q), .resp(s_resp), .resp_valid(s_valid), .resp_ready(s_ready),
    .unstable_cnt(s_unst)
  );

  assign s_q = s_pat[s_sel];

  // cell model: count evaluations per cell on each rising puf_en
  always @(posedge clk) begin
    if (rst || model_clr) begin
      for (int i = 0; i < 8; i++) ev[i] <= 0;
      en_prev <= 1'b0;
    end else begin
      en_prev <= puf_en;
      if (puf_en && !en_prev) ev[puf_sel] <= ev[puf_sel] + 1;
    end
  end

  always_comb begin
    int k;
    k = ev[puf_sel] - 1;
    if (k < 0) k = 0;
    if (k > 4) k = 4;
    puf_q = seq[puf_sel][k];
  end

  // window monitor: measures excite/low run lengths and puf_sel progression
  always @(negedge clk) begin
    if (mon_clr) begin
      n_exc = 0; n_exc_bad = 0; n_low = 0; n_low_bad = 0; n_sel_bad = 0;
      hi_run = 0; lo_run = 0; sel_max = 0; last_sel = 3'd0; seen = 1'b0;
    end else if (puf_en) begin
      if (seen && lo_run > 0) begin
        n_low++;
        if (lo_run != ((puf_sel == last_sel) ? 5 : 6)) n_low_bad++;
      end
      if (!seen && puf_sel != 3'd0) n_sel_bad++;
      if (puf_sel != last_sel && puf_sel != last_sel + 3'd1) n_sel_bad++;
      if (!puf_excite) n_exc_bad++;
      if (int'(puf_sel) > sel_max) sel_max = int'(puf_sel);
      lo_run = 0; hi_run++; seen = 1'b1; last_sel = puf_sel;
    end else begin
      if (hi_run > 0) begin
        n_exc++;
        if (hi_run != 4) n_exc_bad++;
        hi_run = 0;
      end
      if (puf_excite) n_exc_bad++;
      if (seen) lo_run++;
    end
  end

  task automatic set_stable(input logic [7:0] pat);
    for (int c = 0; c < 8; c++) seq[c] = pat[c] ? 5'b11111 : 5'b00000;
  endtask

  task automatic do_read(input logic [7:0] exp_resp, input logic [3:0] exp_unst, input bit bp);
    exp_t e;
    exp_t got;
    int lat;
    e.resp = exp_resp; e.unst = exp_unst; e.lat = 369;
    sb.push_back(e);
    model_clr = 1'b1; resp_ready = !bp;
    @(posedge clk); #1;
    model_clr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    while (!resp_valid && lat < 2000) begin
      start = (bp && (lat % 37 == 0)) ? 1'b1 : 1'b0;
      checks++;
      if (puf_pre !== 1'b1 || puf_clr !== 1'b0 || (lat > 1 && busy !== 1'b1)) begin
        errors++; $display("FAIL busy_consts pre=%b clr=%b busy=%b want 1 0 1", puf_pre, puf_clr, busy);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    got = sb.pop_front();
    checks++;
    if (!resp_valid) begin
      errors++; $display("FAIL valid_timeout got no resp_valid after %0d cycles", lat);
      return;
    end
    checks++;
    if (lat != got.lat) begin errors++; $display("FAIL latency got %0d want %0d", lat, got.lat); end
    checks++;
    if (resp !== got.resp) begin errors++; $display("FAIL resp got %h want %h", resp, got.resp); end
    checks++;
    if (unstable_cnt !== got.unst) begin errors++; $display("FAIL unstable_cnt got %0d want %0d", unstable_cnt, got.unst); end
    checks++;
    if (busy !== 1'b0 || puf_sel !== 3'd7) begin errors++; $display("FAIL done_state busy=%b sel=%0d want 0 7", busy, puf_sel); end
    if (bp) begin
      for (int i = 0; i < 20; i++) begin
        start = i[0];
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp !== got.resp || busy !== 1'b0 || unstable_cnt !== got.unst) begin
          errors++; $display("FAIL hold cyc %0d valid=%b resp=%h busy=%b want 1 %h 0", i, resp_valid, resp, busy, got.resp);
        end
      end
      start = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got %b want 0", resp_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || puf_en !== 1'b0) begin errors++; $display("FAIL idle_after busy=%b en=%b want 0 0", busy, puf_en); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; resp_ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
    model_clr = 1'b0; mon_clr = 1'b1; s_pat = 4'b1100;
    set_stable(8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || puf_en !== 1'b0 || puf_excite !== 1'b0 || resp_valid !== 1'b0 ||
          resp !== 8'h00 || unstable_cnt !== 4'd0 || puf_sel !== 3'd0 || puf_pre !== 1'b1 || puf_clr !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d busy=%b en=%b exc=%b valid=%b resp=%h unst=%0d sel=%0d pre=%b clr=%b want all 0, pre=1",
                 i, busy, puf_en, puf_excite, resp_valid, resp, unstable_cnt, puf_sel, puf_pre, puf_clr);
      end
    end
  endtask

  task automatic test_stable();
    set_stable(8'hA5);
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    do_read(8'hA5, 4'd0, 1'b0);
    checks++;
    if (n_exc != 40 || n_exc_bad != 0) begin errors++; $display("FAIL excite_windows got %0d bad %0d want 40 bad 0", n_exc, n_exc_bad); end
    checks++;
    if (n_low != 39 || n_low_bad != 0) begin errors++; $display("FAIL release_windows got %0d bad %0d want 39 bad 0", n_low, n_low_bad); end
    checks++;
    if (n_sel_bad != 0 || sel_max != 7) begin errors++; $display("FAIL sel_steps bad %0d max %0d want 0 7", n_sel_bad, sel_max); end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (ev[c] != 5) begin errors++; $display("FAIL samples cell %0d got %0d want 5", c, ev[c]); end
    end
    mon_clr = 1'b1;
  endtask

  task automatic test_noise();
    set_stable(8'h00);
    seq[3] = 5'b10101;
    seq[6] = 5'b00100;
    do_read(8'h08, 4'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_stable(8'h3C);
    do_read(8'h3C, 4'd0, 1'b1);
    set_stable(8'hC3);
    seq[0] = 5'b11010;
    do_read(8'hC3, 4'd1, 1'b0);
  endtask

  task automatic test_reset_midop();
    int n;
    set_stable(8'hA5);
    model_clr = 1'b1;
    @(posedge clk); #1;
    model_clr = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(puf_sel == 3'd4 && puf_en) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(puf_sel == 3'd4 && puf_en)) begin errors++; $display("FAIL midop_reach sel=%0d en=%b want 4 1", puf_sel, puf_en); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp !== 8'h00 || puf_sel !== 3'd0 || unstable_cnt !== 4'd0 || puf_en !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset busy=%b resp=%h sel=%0d unst=%0d en=%b valid=%b want all 0", busy, resp, puf_sel, unstable_cnt, puf_en, resp_valid);
    end
    do_read(8'hA5, 4'd0, 1'b0);
  endtask

  task automatic test_corner();
    int lat;
    s_pat = 4'b1100;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 1;
    while (!s_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!s_valid || lat != 17) begin errors++; $display("FAIL corner_latency got %0d valid=%b want 17", lat, s_valid); end
    checks++;
    if (s_resp !== 4'hC || s_unst !== 3'd0) begin errors++; $display("FAIL corner_resp got %h unst %0d want c 0", s_resp, s_unst); end
    checks++;
    if (s_busy !== 1'b0 || s_en !== 1'b0 || s_exc !== 1'b0 || s_pre !== 1'b1 || s_clr !== 1'b0 || s_sel !== 2'd3) begin
      errors++; $display("FAIL corner_done busy=%b en=%b exc=%b pre=%b clr=%b sel=%0d", s_busy, s_en, s_exc, s_pre, s_clr, s_sel);
    end
    @(posedge clk); #1;
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL corner_valid_drop got %b want 0", s_valid); end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_noise();
    test_back_to_back();
    test_reset_midop();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_resp_reader.md
Name: puf_resp_reader

Overview:
- Read-side controller for the butterfly PUF cell array.
- Drives each cell through the excite/release sequence the cell expects.
- Samples each cell's q output several times, majority-votes every bit, and assembles a RESP_WIDTH response word.
- Presents the word on a valid/ready handshake to the key/authentication logic, with a count of bits that were not unanimous.

Parameters:
- RESP_WIDTH, 8, number of PUF cells read = response bits; cell index i maps to resp[i].
- VOTES, 5, evaluations per cell; must be odd and ≥1.
- SETTLE_CYC, 4, cycles held in each of the excite and release phases; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one full response read; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until resp_valid rises.
- puf_sel  out  clog2(RESP_WIDTH)  index of the cell currently addressed.
- puf_en  out  1  cell enable; 1 in the excite phase, 0 otherwise.
- puf_excite  out  1  cell excite; 1 in the excite phase, 0 otherwise.
- puf_clr  out  1  constant 0.
- puf_pre  out  1  constant 1.
- puf_q  in  1  q1 of the selected cell; synchronous to clk.
- resp  out  RESP_WIDTH  assembled response; stable while resp_valid=1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- unstable_cnt  out  clog2(RESP_WIDTH+1)  number of bits whose VOTES samples were not all equal.

Behaviour:
Reset (rst=1 at a rising edge; takes priority over everything, including mid-operation):
- state→IDLE.
- busy, puf_en, puf_excite, resp_valid = 0.
- puf_sel, resp, unstable_cnt, vote counter, ones counter and phase counter = 0.
- The next read starts clean; no partial result is retained.

FSM states: IDLE, EXCITE, RELEASE, SAMPLE, NEXT, DONE.
- IDLE:
  - When start=1: clear resp, unstable_cnt, puf_sel, vote counter and ones counter.
  - Go to EXCITE; busy=1 from the next cycle.
- EXCITE:
  - puf_en=1, puf_excite=1 for exactly SETTLE_CYC cycles, then go to RELEASE.
- RELEASE:
  - puf_en=0, puf_excite=0 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Capture puf_q: ones += puf_q; votes += 1.
  - If votes < VOTES after the increment, go to EXCITE; otherwise go to NEXT.
- NEXT (1 cycle):
  - bit = (ones > VOTES/2, integer division).
  - resp[puf_sel] = bit.
  - If ones ≠ 0 and ones ≠ VOTES, unstable_cnt += 1.
  - Clear votes and ones.
  - If puf_sel = RESP_WIDTH-1, go to DONE; otherwise puf_sel += 1 and go to EXCITE.
- DONE:
  - resp_valid=1, busy=0; resp and unstable_cnt held.
  - Transfer occurs in a cycle with resp_valid & resp_ready; the next state is IDLE with resp_valid=0.
  - If resp_ready=1 on DONE's first cycle, valid lasts exactly one cycle.

Rules and boundary conditions:
- start is ignored outside IDLE, including in DONE; no queuing.
- puf_sel never exceeds RESP_WIDTH-1; it stays at RESP_WIDTH-1 through DONE and returns to 0 on the next accept.
- puf_clr and puf_pre are constants, never toggled, including during reset.
- Only registered outputs; no combinational path from any input to any output.
- ones counter width is clog2(VOTES+1); no overflow is possible.
- unstable_cnt saturates naturally at RESP_WIDTH.
- VOTES=1: every bit is stable; unstable_cnt is always 0.

Latency:
- Per evaluation: 2*SETTLE_CYC+1 cycles.
- Per bit: VOTES*(2*SETTLE_CYC+1)+1 cycles.
- start accept to first resp_valid cycle: 1 + RESP_WIDTH*(VOTES*(2*SETTLE_CYC+1)+1) cycles.
- Defaults: 1+8*46 = 369 cycles.

Test Plan:
- Reset/idle: hold rst 3 cycles, then idle 10 cycles with start=0 → all outputs 0, puf_pre=1, puf_clr=0, no puf_en activity.
- Stable pattern: cell model returns bit i of 8'hA5 constantly; pulse start → resp_valid exactly 369 cycles later, resp=8'hA5, unstable_cnt=0. Also check:
  - each EXCITE window is 4 cycles, each RELEASE window is 4 cycles;
  - each cell gets 5 samples;
  - puf_sel steps 0..7.
- Majority with noise: cell 3 returns 1,0,1,0,1 and cell 6 returns 0,0,1,0,0; all other cells 0 → resp=8'h08, unstable_cnt=2.
- Handshake back-pressure: resp_ready=0 for 20 cycles after valid, with start pulses during busy and DONE → resp held, valid held, start ignored. Assert resp_ready for 1 cycle → valid drops next cycle, state IDLE; a new start is accepted.
- Reset mid-operation: assert rst during the excite phase of cell 4 → next cycle busy=0, resp=0, puf_sel=0, unstable_cnt=0. A following start produces the correct full response with full latency.
- Parameter corner: VOTES=1, SETTLE_CYC=1, RESP_WIDTH=4, cell pattern 4'b1100 → resp=4'hC, unstable_cnt=0, latency 1+4*4=17 cycles.
